// File: rtl/mem_writeback.sv
// Memory/writeback stage: accepts one op per handshake, runs a data-memory
// transaction for loads/stores, and drives the register-file write port.
module mem_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_en,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misalign,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WB   = 3'd1;
  localparam logic [2:0] ST_REQ  = 3'd2;
  localparam logic [2:0] ST_RSP  = 3'd3;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the sender holds valid and payload stable until that edge.
  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic                  misalign_q, misalign_d;

  logic                  is_mem;
  logic                  f3_legal;
  logic                  addr_bad;
  logic                  op_bad;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [3:0]            st_strb;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  req_st;

  // Decode legality of the incoming op before it is accepted.
  always_comb begin
    is_mem = mem_read | mem_write;
    if (mem_write) begin
      f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    addr_bad = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
               ((funct3 == 3'b010) && (alu_result[1:0] != 2'b00));
    op_bad   = is_mem && ((mem_read && mem_write) || !f3_legal || addr_bad);
  end

  // Load lane select and extension; data_q still holds the address in RSP.
  always_comb begin
    case (data_q[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = data_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        st_strb = 4'b0001 << data_q[1:0];
        st_data = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {data_q[1], 1'b0};
        st_data = {2{sdata_q[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = sdata_q;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    sdata_d    = sdata_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    we_d       = we_q;
    f3_d       = f3_q;
    misalign_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = alu_result;
          sdata_d = store_data;
          rd_d    = rd;
          rw_d    = reg_write;
          we_d    = mem_write;
          f3_d    = funct3;
          if (op_bad) begin
            misalign_d = 1'b1;
          end else if (is_mem) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = we_q ? ST_IDLE : ST_RSP;
        end
      end
      ST_RSP: begin
        if (mem_rsp_valid) begin
          data_d  = ld_ext;
          state_d = ST_WB;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      sdata_q    <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      sdata_q    <= sdata_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    in_ready      = (state_q == ST_IDLE);
    mem_req_valid = (state_q == ST_REQ);
    req_st        = mem_req_valid && we_q;
    mem_addr      = mem_req_valid ? {data_q[DATA_WIDTH-1:2], 2'b00} : '0;
    mem_we        = req_st;
    mem_wstrb     = req_st ? st_strb : 4'b0000;
    mem_wdata     = req_st ? st_data : '0;
    wb_en         = (state_q == ST_WB) && rw_q && (rd_q != '0);
    wb_addr       = wb_en ? rd_q : '0;
    wb_data       = wb_en ? data_q : '0;
    misalign      = misalign_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: a vector table of single ops plus
// hand-written sequences for stalls, reset mid-transaction and stray responses.
module tb_mem_writeback;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        misalign;
  logic [2:0]  dbg_state;

  int n_pass;
  int n_total;

  mem_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .misalign(misalign), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic        exp_mis;
    logic        exp_wben;
    logic [31:0] exp_wbdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    alu_result    = '0;
    store_data    = '0;
    rd            = '0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    funct3        = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
  endtask

  task automatic drive_op(input vec_t v);
    in_valid   = 1'b1;
    alu_result = v.alu;
    store_data = v.sd;
    rd         = v.rd;
    reg_write  = v.rw;
    mem_read   = v.mr;
    mem_write  = v.mw;
    funct3     = v.f3;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d_", idx);
    @(posedge clk); #1;
    drive_op(v);
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk({p, "in_ready_pre"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    if (v.exp_mis) begin
      chk({p, "misalign"}, {31'd0, misalign}, 32'd1);
      chk({p, "no_req"}, {31'd0, mem_req_valid}, 32'd0);
      chk({p, "no_wb"}, {31'd0, wb_en}, 32'd0);
      chk({p, "in_ready_mis"}, {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk({p, "misalign_end"}, {31'd0, misalign}, 32'd0);
      chk({p, "no_req2"}, {31'd0, mem_req_valid}, 32'd0);
      chk({p, "no_wb2"}, {31'd0, wb_en}, 32'd0);
    end else if (!v.mr && !v.mw) begin
      chk({p, "wb_en"}, {31'd0, wb_en}, {31'd0, v.exp_wben});
      if (v.exp_wben) begin
        chk({p, "wb_addr"}, {27'd0, wb_addr}, {27'd0, v.rd});
        chk({p, "wb_data"}, wb_data, v.exp_wbdata);
      end
      chk({p, "busy"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk({p, "wb_once"}, {31'd0, wb_en}, 32'd0);
      chk({p, "ready_back"}, {31'd0, in_ready}, 32'd1);
    end else begin
      chk({p, "req_valid"}, {31'd0, mem_req_valid}, 32'd1);
      chk({p, "mem_addr"}, mem_addr, {v.alu[31:2], 2'b00});
      chk({p, "mem_we"}, {31'd0, mem_we}, {31'd0, v.mw});
      chk({p, "wstrb"}, {28'd0, mem_wstrb}, {28'd0, v.exp_wstrb});
      if (v.mw) chk({p, "wdata"}, mem_wdata, v.exp_wdata);
      chk({p, "no_wb_req"}, {31'd0, wb_en}, 32'd0);
      if (v.mw) begin
        @(negedge clk);
        chk({p, "st_done"}, {31'd0, mem_req_valid}, 32'd0);
        chk({p, "st_ready"}, {31'd0, in_ready}, 32'd1);
        chk({p, "st_no_wb"}, {31'd0, wb_en}, 32'd0);
      end else begin
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = v.rdata;
        @(negedge clk);
        chk({p, "rsp_no_wb"}, {31'd0, wb_en}, 32'd0);
        chk({p, "rsp_no_req"}, {31'd0, mem_req_valid}, 32'd0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        @(negedge clk);
        chk({p, "ld_wb_en"}, {31'd0, wb_en}, {31'd0, v.exp_wben});
        if (v.exp_wben) begin
          chk({p, "ld_wb_addr"}, {27'd0, wb_addr}, {27'd0, v.rd});
          chk({p, "ld_wb_data"}, wb_data, v.exp_wbdata);
        end
        @(negedge clk);
        chk({p, "ld_ready_back"}, {31'd0, in_ready}, 32'd1);
      end
    end
    mem_req_ready = 1'b0;
  endtask

  initial begin
    vec_t sh;
    vec_t lw;
    n_pass  = 0;
    n_total = 0;
    idle_inputs();

    // rw rd mr mw f3 alu sd rdata | mis wben wbdata wstrb wdata
    vecs.push_back('{1'b1, 5'd5,  1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd0,  1'b0, 1'b0, 3'b000, 32'hAAAA_5555, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 5'd7,  1'b0, 1'b0, 3'b000, 32'h0000_0001, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd4,  1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b0, 1'b1, 32'hFFFF_FF80, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd4,  1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b0, 1'b1, 32'h0000_0080, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd6,  1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_0000, 1'b0, 1'b1, 32'hFFFF_80FF, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd6,  1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_8001, 1'b0, 1'b1, 32'h0000_8001, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd9,  1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd10, 1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_7F00, 1'b0, 1'b1, 32'h0000_007F, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 5'd0,  1'b0, 1'b1, 3'b000, 32'h0000_0012, 32'h0000_00AB, 32'h0, 1'b0, 1'b0, 32'h0, 4'b0100, 32'hABAB_ABAB});
    vecs.push_back('{1'b0, 5'd0,  1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 32'h0, 4'b1111, 32'hCAFE_F00D});
    vecs.push_back('{1'b1, 5'd2,  1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd2,  1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd2,  1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd2,  1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 5'd0,  1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h0000_0011, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 5'd0,  1'b0, 1'b1, 3'b001, 32'h0000_0021, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0});

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_req", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Store with mem_req_ready low for three cycles: request must stay stable.
    sh = '{1'b0, 5'd0, 1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h0000_BEEF, 32'h0, 1'b0, 1'b0, 32'h0, 4'b1100, 32'hBEEF_BEEF};
    @(posedge clk); #1;
    drive_op(sh);
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("sh_req_%0d", i), {31'd0, mem_req_valid}, 32'd1);
      chk($sformatf("sh_addr_%0d", i), mem_addr, 32'h0000_0020);
      chk($sformatf("sh_we_%0d", i), {31'd0, mem_we}, 32'd1);
      chk($sformatf("sh_wstrb_%0d", i), {28'd0, mem_wstrb}, {28'd0, sh.exp_wstrb});
      chk($sformatf("sh_wdata_%0d", i), mem_wdata, sh.exp_wdata);
      chk($sformatf("sh_no_wb_%0d", i), {31'd0, wb_en}, 32'd0);
      @(posedge clk);
      if (i == 2) #1 mem_req_ready = 1'b1;
    end
    #1 mem_req_ready = 1'b0;
    @(negedge clk);
    chk("sh_done", {31'd0, mem_req_valid}, 32'd0);
    chk("sh_ready", {31'd0, in_ready}, 32'd1);
    chk("sh_no_wb_after", {31'd0, wb_en}, 32'd0);

    // A response while idle is ignored.
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("idle_rsp_no_wb", {31'd0, wb_en}, 32'd0);
    chk("idle_rsp_state", {29'd0, dbg_state}, 32'd0);

    // Load stalls in RSP, then reset hits before the response arrives.
    lw = '{1'b1, 5'd3, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0};
    @(posedge clk); #1;
    drive_op(lw);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rsp_wait_state_%0d", i), {29'd0, dbg_state}, 32'd3);
      chk($sformatf("rsp_wait_busy_%0d", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("rsp_wait_no_wb_%0d", i), {31'd0, wb_en}, 32'd0);
    end
    rst_n = 1'b0;
    #2;
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_state", {29'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("late_rsp_wb_%0d", i), {31'd0, wb_en}, 32'd0);
      chk($sformatf("late_rsp_wb_data_%0d", i), wb_data, 32'd0);
      chk($sformatf("late_rsp_state_%0d", i), {29'd0, dbg_state}, 32'd0);
      chk($sformatf("late_rsp_ready_%0d", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("late_rsp_req_%0d", i), {31'd0, mem_req_valid}, 32'd0);
      chk($sformatf("late_rsp_mis_%0d", i), {31'd0, misalign}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
